// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN layer pipeline: sample width, default map size,
// the pooling FSM state type and a constant-evaluable clog2.
package cnn_pkg;

   localparam int CNN_DATA_W = 8;
   localparam int CNN_IMG_W  = 26;
   localparam int CNN_IMG_H  = 26;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      READ  = 3'd1,
      DRAIN = 3'd2,
      OUT   = 3'd3,
      FIN   = 3'd4
   } pool_state_t;

   function automatic int clog2(input int value);
      int r;
      r = 0;
      while ((1 << r) < value) r++;
      return r;
   endfunction

endpackage

// File: rtl/pool_addr_gen.sv
// Incremental read-address generator for max-pooling: walks j/i inside a window,
// then window column, window row and channel, using only adders.
module pool_addr_gen import cnn_pkg::*; #(
   parameter int IMG_W    = CNN_IMG_W,
   parameter int IMG_H    = CNN_IMG_H,
   parameter int POOL     = 2,
   parameter int CHANNELS = 1,
   parameter int ADDR_W   = 10,
   parameter int CH_W     = clog2(CHANNELS) + 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              adv,
   output logic [ADDR_W-1:0] rd_addr,
   output logic [CH_W-1:0]   ch,
   output logic              first_in_win,
   output logic              last_in_win,
   output logic              last_all
);

   localparam int OW  = IMG_W / POOL;
   localparam int OH  = IMG_H / POOL;
   localparam int PW  = clog2(POOL) + 1;
   localparam int OWW = clog2(OW) + 1;
   localparam int OHW = clog2(OH) + 1;

   // Stepping from the last sample of a window row to the first of the next one.
   localparam logic [ADDR_W-1:0] ROW_STEP  = ADDR_W'(IMG_W - (POOL - 1));
   localparam logic [ADDR_W-1:0] WIN_STEP  = ADDR_W'(POOL);
   localparam logic [ADDR_W-1:0] BAND_STEP = ADDR_W'(POOL * IMG_W);
   localparam logic [ADDR_W-1:0] MAP_STEP  = ADDR_W'(IMG_W * IMG_H);

   logic [PW-1:0]     j_reg, i_reg;
   logic [OWW-1:0]    c_reg;
   logic [OHW-1:0]    r_reg;
   logic [CH_W-1:0]   ch_reg;
   logic [ADDR_W-1:0] win_base_reg, band_base_reg, map_base_reg;
   logic              j_last, i_last, c_last, r_last, ch_last;

   assign j_last  = (j_reg == PW'(POOL - 1));
   assign i_last  = (i_reg == PW'(POOL - 1));
   assign c_last  = (c_reg == OWW'(OW - 1));
   assign r_last  = (r_reg == OHW'(OH - 1));
   assign ch_last = (ch_reg == CH_W'(CHANNELS - 1));

   assign first_in_win = (j_reg == '0) && (i_reg == '0);
   assign last_in_win  = j_last && i_last;
   assign last_all     = last_in_win && c_last && r_last && ch_last;
   assign ch           = ch_reg;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         j_reg         <= '0;
         i_reg         <= '0;
         c_reg         <= '0;
         r_reg         <= '0;
         ch_reg        <= '0;
         win_base_reg  <= '0;
         band_base_reg <= '0;
         map_base_reg  <= '0;
         rd_addr       <= '0;
      end else if (clr) begin
         j_reg         <= '0;
         i_reg         <= '0;
         c_reg         <= '0;
         r_reg         <= '0;
         ch_reg        <= '0;
         win_base_reg  <= '0;
         band_base_reg <= '0;
         map_base_reg  <= '0;
         rd_addr       <= '0;
      end else if (adv) begin
         if (!j_last) begin
            j_reg   <= j_reg + PW'(1);
            rd_addr <= rd_addr + ADDR_W'(1);
         end else begin
            j_reg <= '0;
            if (!i_last) begin
               i_reg   <= i_reg + PW'(1);
               rd_addr <= rd_addr + ROW_STEP;
            end else begin
               i_reg <= '0;
               if (!c_last) begin
                  c_reg        <= c_reg + OWW'(1);
                  win_base_reg <= win_base_reg + WIN_STEP;
                  rd_addr      <= win_base_reg + WIN_STEP;
               end else begin
                  c_reg <= '0;
                  if (!r_last) begin
                     r_reg         <= r_reg + OHW'(1);
                     band_base_reg <= band_base_reg + BAND_STEP;
                     win_base_reg  <= band_base_reg + BAND_STEP;
                     rd_addr       <= band_base_reg + BAND_STEP;
                  end else begin
                     r_reg <= '0;
                     if (!ch_last) begin
                        ch_reg        <= ch_reg + CH_W'(1);
                        map_base_reg  <= map_base_reg + MAP_STEP;
                        band_base_reg <= map_base_reg + MAP_STEP;
                        win_base_reg  <= map_base_reg + MAP_STEP;
                        rd_addr       <= map_base_reg + MAP_STEP;
                     end else begin
                        // Whole run finished: park everything back at the origin.
                        ch_reg        <= '0;
                        map_base_reg  <= '0;
                        band_base_reg <= '0;
                        win_base_reg  <= '0;
                        rd_addr       <= '0;
                     end
                  end
               end
            end
         end
      end
   end

endmodule

// File: rtl/pool_relu_layer.sv
// Max-pool + ReLU layer reading feature maps from RAM, one result per window.
// MAXPOOL_RELU_EN: when defined, negative window maxima are clamped to zero.
module pool_relu_layer import cnn_pkg::*; #(
   parameter int DATA_W   = CNN_DATA_W,
   parameter int IMG_W    = CNN_IMG_W,
   parameter int IMG_H    = CNN_IMG_H,
   parameter int POOL     = 2,
   parameter int CHANNELS = 1,
   parameter int ADDR_W   = 10
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   output logic                       rd_en,
   output logic [ADDR_W-1:0]          rd_addr,
   input  logic [DATA_W-1:0]          d_in,
   output logic [DATA_W-1:0]          d_out,
   output logic [clog2(CHANNELS):0]   d_out_ch,
   output logic                       d_out_valid,
   input  logic                       d_out_ready,
   output logic                       busy,
   output logic                       done
);

   localparam int CH_W = clog2(CHANNELS) + 1;

   pool_state_t       state_reg, state_next;
   logic              start_acc;
   logic              smp_vld_reg, smp_first_reg, last_win_reg;
   logic [DATA_W-1:0] acc_reg, win_max, pooled;
   logic [CH_W-1:0]   win_ch_reg, gen_ch;
   logic              gen_first, gen_last_in_win, gen_last_all;

   assign start_acc   = (state_reg == IDLE) && start;
   assign rd_en       = (state_reg == READ);
   assign d_out_valid = (state_reg == OUT);
   assign done        = (state_reg == FIN);
   assign busy        = (state_reg == READ) || (state_reg == DRAIN) || (state_reg == OUT);

   pool_addr_gen #(
      .IMG_W    (IMG_W),
      .IMG_H    (IMG_H),
      .POOL     (POOL),
      .CHANNELS (CHANNELS),
      .ADDR_W   (ADDR_W),
      .CH_W     (CH_W)
   ) u_addr_gen (
      .clk          (clk),
      .rst          (rst),
      .clr          (start_acc),
      .adv          (rd_en),
      .rd_addr      (rd_addr),
      .ch           (gen_ch),
      .first_in_win (gen_first),
      .last_in_win  (gen_last_in_win),
      .last_all     (gen_last_all)
   );

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (start) state_next = READ;
         READ:    if (gen_last_in_win) state_next = DRAIN;
         DRAIN:   state_next = OUT;
         OUT:     if (d_out_ready) state_next = last_win_reg ? FIN : READ;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Running signed maximum; the first sample of each window overrides the old value.
   assign win_max = (smp_first_reg || ($signed(d_in) > $signed(acc_reg))) ? d_in : acc_reg;

`ifdef MAXPOOL_RELU_EN
   assign pooled = win_max[DATA_W-1] ? '0 : win_max;
`else
   assign pooled = win_max;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_reg     <= IDLE;
         smp_vld_reg   <= 1'b0;
         smp_first_reg <= 1'b0;
         last_win_reg  <= 1'b0;
         win_ch_reg    <= '0;
         acc_reg       <= '0;
         d_out         <= '0;
         d_out_ch      <= '0;
      end else begin
         state_reg     <= state_next;
         smp_vld_reg   <= rd_en;
         smp_first_reg <= rd_en && gen_first;
         if (smp_vld_reg) acc_reg <= win_max;
         // The counters move on with the last read, so capture the window's identity here.
         if (rd_en && gen_last_in_win) begin
            last_win_reg <= gen_last_all;
            win_ch_reg   <= gen_ch;
         end
         if (state_reg == DRAIN) begin
            d_out    <= pooled;
            d_out_ch <= win_ch_reg;
         end
      end
   end

endmodule

// File: tb/tb_pool_relu_layer.sv
// Directed bench for pool_relu_layer: three instances (4x4x1, 4x4x2, 5x5x1) with RAM models.
module tb_pool_relu_layer;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   errors = 0;
   int   checks = 0;

   always #5 clk = ~clk;

   // Instance A: 4x4, one channel
   logic       a_start = 1'b0, a_ready = 1'b1;
   logic       a_rd_en, a_valid, a_busy, a_done;
   logic [5:0] a_rd_addr;
   logic [7:0] a_d_in = 8'h00, a_d_out;
   logic [0:0] a_ch;
   logic [7:0] mem_a [0:63];
   logic [7:0] res_a [0:15];

   // Instance B: 4x4, two channels
   logic       b_start = 1'b0, b_ready = 1'b1;
   logic       b_rd_en, b_valid, b_busy, b_done;
   logic [5:0] b_rd_addr;
   logic [7:0] b_d_in = 8'h00, b_d_out;
   logic [1:0] b_ch;
   logic [7:0] mem_b [0:63];

   // Instance C: 5x5, one channel
   logic       c_start = 1'b0, c_ready = 1'b1;
   logic       c_rd_en, c_valid, c_busy, c_done;
   logic [5:0] c_rd_addr;
   logic [7:0] c_d_in = 8'h00, c_d_out;
   logic [0:0] c_ch;
   logic [7:0] mem_c [0:63];

   pool_relu_layer #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .POOL(2), .CHANNELS(1), .ADDR_W(6)) dut_a (
      .clk(clk), .rst(rst), .start(a_start), .rd_en(a_rd_en), .rd_addr(a_rd_addr), .d_in(a_d_in),
      .d_out(a_d_out), .d_out_ch(a_ch), .d_out_valid(a_valid), .d_out_ready(a_ready),
      .busy(a_busy), .done(a_done));

   pool_relu_layer #(.DATA_W(8), .IMG_W(4), .IMG_H(4), .POOL(2), .CHANNELS(2), .ADDR_W(6)) dut_b (
      .clk(clk), .rst(rst), .start(b_start), .rd_en(b_rd_en), .rd_addr(b_rd_addr), .d_in(b_d_in),
      .d_out(b_d_out), .d_out_ch(b_ch), .d_out_valid(b_valid), .d_out_ready(b_ready),
      .busy(b_busy), .done(b_done));

   pool_relu_layer #(.DATA_W(8), .IMG_W(5), .IMG_H(5), .POOL(2), .CHANNELS(1), .ADDR_W(6)) dut_c (
      .clk(clk), .rst(rst), .start(c_start), .rd_en(c_rd_en), .rd_addr(c_rd_addr), .d_in(c_d_in),
      .d_out(c_d_out), .d_out_ch(c_ch), .d_out_valid(c_valid), .d_out_ready(c_ready),
      .busy(c_busy), .done(c_done));

   // Registered-read RAM models
   always @(posedge clk) begin
      if (a_rd_en) a_d_in <= mem_a[a_rd_addr];
      if (b_rd_en) b_d_in <= mem_b[b_rd_addr];
      if (c_rd_en) c_d_in <= mem_c[c_rd_addr];
   end

   // Runs instance A from a start pulse until done; records handshaken results.
   // stall_res: result index whose handshake is delayed by 10 cycles (-1 = none).
   // extra_start_cyc: cycle in which a second start pulse is driven (-1 = none).
   task automatic run_a(input int stall_res, input int extra_start_cyc,
                        output int nres, output int first_v, output int ndone,
                        output int done_cyc, output int nrd, output int stall_bad);
      int         stall_left;
      bit         stalled;
      logic [7:0] held;
      nres = 0; first_v = -1; ndone = 0; done_cyc = -1; nrd = 0; stall_bad = 0;
      stall_left = 0; stalled = 1'b0; held = 8'h00;
      for (int k = 0; k < 16; k++) res_a[k] = 8'hAA;
      a_ready = 1'b1;
      @(negedge clk);
      a_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_start = 1'b0;
      for (int cyc = 1; cyc < 200 && ndone == 0; cyc++) begin
         if (a_rd_en) nrd++;
         if (a_done) begin ndone++; done_cyc = cyc; end
         if (a_valid && first_v < 0) first_v = cyc;
         if (stall_left > 0) begin
            if (a_d_out !== held || a_valid !== 1'b1 || a_rd_en !== 1'b0) stall_bad++;
            stall_left--;
            if (stall_left == 0) a_ready = 1'b1;
         end else if (a_valid && !stalled && nres == stall_res) begin
            stalled = 1'b1;
            held = a_d_out;
            a_ready = 1'b0;
            stall_left = 10;
         end
         if (a_valid && a_ready) begin
            if (nres < 16) res_a[nres] = a_d_out;
            nres++;
         end
         a_start = (cyc == extra_start_cyc);
         @(posedge clk);
         @(negedge clk);
      end
      a_start = 1'b0;
      // A few idle cycles to catch any stray done pulse or result
      for (int k = 0; k < 5; k++) begin
         if (a_done) ndone++;
         if (a_valid) nres++;
         @(posedge clk);
         @(negedge clk);
      end
   endtask

   task automatic test_reset;
      repeat (3) @(negedge clk);
      checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", a_busy); end
      checks++; if (a_rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en got %b want 0", a_rd_en); end
      checks++; if (a_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", a_valid); end
      checks++; if (a_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", a_done); end
      checks++; if (a_d_out !== 8'h00) begin errors++; $display("FAIL reset_d_out got %h want 00", a_d_out); end
      checks++; if (a_rd_addr !== 6'd0) begin errors++; $display("FAIL reset_rd_addr got %0d want 0", a_rd_addr); end
      checks++;
      if ({b_busy, b_valid, c_busy, c_valid} !== 4'b0000) begin
         errors++; $display("FAIL reset_bc got %b want 0000", {b_busy, b_valid, c_busy, c_valid});
      end
      rst = 1'b1;
      repeat (2) @(negedge clk);
   endtask

   task automatic test_basic;
      int         nres, first_v, ndone, done_cyc, nrd, stall_bad;
      logic [7:0] expv [4] = '{8'd6, 8'd8, 8'd14, 8'd16};
      for (int k = 0; k < 16; k++) mem_a[k] = 8'(k + 1);
      run_a(-1, -1, nres, first_v, ndone, done_cyc, nrd, stall_bad);
      checks++; if (nres != 4) begin errors++; $display("FAIL basic_count got %0d want 4", nres); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (res_a[k] !== expv[k]) begin errors++; $display("FAIL basic_res%0d got %0d want %0d", k, res_a[k], expv[k]); end
         $display("basic result %0d: d_out=%0d", k, res_a[k]);
      end
      checks++; if (first_v != 6) begin errors++; $display("FAIL basic_first_valid got %0d want 6", first_v); end
      checks++; if (ndone != 1) begin errors++; $display("FAIL basic_done_count got %0d want 1", ndone); end
      checks++; if (done_cyc != 25) begin errors++; $display("FAIL basic_done_cycle got %0d want 25", done_cyc); end
      checks++; if (nrd != 16) begin errors++; $display("FAIL basic_reads got %0d want 16", nrd); end
   endtask

   task automatic test_relu;
      int         nres, first_v, ndone, done_cyc, nrd, stall_bad;
`ifdef MAXPOOL_RELU_EN
      logic [7:0] expv [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
`else
      logic [7:0] expv [4] = '{8'hFD, 8'hFF, 8'hF9, 8'hFE};
`endif
      for (int k = 0; k < 16; k++) mem_a[k] = 8'h80;
      mem_a[0]  = 8'h9C;  // -100 as first sample of window 0
      mem_a[5]  = 8'hFD;  // window (0,0) max -3
      mem_a[2]  = 8'hFF;  // window (0,1) max -1
      mem_a[12] = 8'hF9;  // window (1,0) max -7
      mem_a[15] = 8'hFE;  // window (1,1) max -2
      run_a(-1, -1, nres, first_v, ndone, done_cyc, nrd, stall_bad);
      checks++; if (nres != 4) begin errors++; $display("FAIL relu_count got %0d want 4", nres); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (res_a[k] !== expv[k]) begin errors++; $display("FAIL relu_res%0d got %h want %h", k, res_a[k], expv[k]); end
         $display("relu result %0d: d_out=%h", k, res_a[k]);
      end
   endtask

   task automatic test_backpressure;
      int         nres, first_v, ndone, done_cyc, nrd, stall_bad;
      logic [7:0] expv [4] = '{8'd6, 8'd8, 8'd14, 8'd16};
      for (int k = 0; k < 16; k++) mem_a[k] = 8'(k + 1);
      run_a(1, -1, nres, first_v, ndone, done_cyc, nrd, stall_bad);
      checks++; if (nres != 4) begin errors++; $display("FAIL bp_count got %0d want 4", nres); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (res_a[k] !== expv[k]) begin errors++; $display("FAIL bp_res%0d got %0d want %0d", k, res_a[k], expv[k]); end
         $display("backpressure result %0d: d_out=%0d", k, res_a[k]);
      end
      checks++; if (stall_bad != 0) begin errors++; $display("FAIL bp_stall_hold got %0d bad cycles want 0", stall_bad); end
      checks++; if (done_cyc != 35) begin errors++; $display("FAIL bp_done_cycle got %0d want 35", done_cyc); end
      checks++; if (nrd != 16) begin errors++; $display("FAIL bp_reads got %0d want 16", nrd); end
   endtask

   task automatic test_channels;
      int         nres, ndone, done_cyc, nrd, addr16;
      logic [7:0] rv [8];
      logic [1:0] rc [8];
      logic [7:0] expv [8] = '{8'd6, 8'd8, 8'd14, 8'd16, 8'd26, 8'd28, 8'd34, 8'd36};
      nres = 0; ndone = 0; done_cyc = -1; nrd = 0; addr16 = -1;
      for (int k = 0; k < 8; k++) begin rv[k] = 8'hAA; rc[k] = 2'b11; end
      for (int k = 0; k < 16; k++) begin mem_b[k] = 8'(k + 1); mem_b[k + 16] = 8'(k + 21); end
      b_ready = 1'b1;
      @(negedge clk);
      b_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_start = 1'b0;
      for (int cyc = 1; cyc < 300 && ndone == 0; cyc++) begin
         if (b_rd_en) begin
            if (nrd == 16) addr16 = int'(b_rd_addr);
            nrd++;
         end
         if (b_valid) begin
            if (nres < 8) begin rv[nres] = b_d_out; rc[nres] = b_ch; end
            nres++;
         end
         if (b_done) begin ndone = 1; done_cyc = cyc; end
         @(posedge clk);
         @(negedge clk);
      end
      checks++; if (nres != 8) begin errors++; $display("FAIL ch_count got %0d want 8", nres); end
      for (int k = 0; k < 8; k++) begin
         checks++;
         if (rv[k] !== expv[k] || rc[k] !== 2'(k / 4)) begin
            errors++; $display("FAIL ch_res%0d got %0d/ch%0d want %0d/ch%0d", k, rv[k], rc[k], expv[k], k / 4);
         end
         $display("channel result %0d: d_out=%0d ch=%0d", k, rv[k], rc[k]);
      end
      checks++; if (addr16 != 16) begin errors++; $display("FAIL ch1_first_addr got %0d want 16", addr16); end
      checks++; if (done_cyc != 49) begin errors++; $display("FAIL ch_done_cycle got %0d want 49", done_cyc); end
   endtask

   task automatic test_odd_size;
      int         nres, ndone, nrd, bad;
      logic [7:0] rv [4];
      logic [7:0] expv [4] = '{8'd7, 8'd9, 8'd17, 8'd19};
      nres = 0; ndone = 0; nrd = 0; bad = 0;
      for (int k = 0; k < 4; k++) rv[k] = 8'hAA;
      for (int k = 0; k < 25; k++) mem_c[k] = 8'(k + 1);
      c_ready = 1'b1;
      @(negedge clk);
      c_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      c_start = 1'b0;
      for (int cyc = 1; cyc < 200 && ndone == 0; cyc++) begin
         if (c_rd_en) begin
            nrd++;
            if ((int'(c_rd_addr) % 5) == 4 || c_rd_addr >= 6'd20) bad++;
         end
         if (c_valid) begin
            if (nres < 4) rv[nres] = c_d_out;
            nres++;
         end
         if (c_done) ndone = 1;
         @(posedge clk);
         @(negedge clk);
      end
      checks++; if (nres != 4) begin errors++; $display("FAIL odd_count got %0d want 4", nres); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (rv[k] !== expv[k]) begin errors++; $display("FAIL odd_res%0d got %0d want %0d", k, rv[k], expv[k]); end
         $display("odd-size result %0d: d_out=%0d", k, rv[k]);
      end
      checks++; if (bad != 0) begin errors++; $display("FAIL odd_trailing_reads got %0d want 0", bad); end
      checks++; if (nrd != 16) begin errors++; $display("FAIL odd_reads got %0d want 16", nrd); end
      checks++; if (ndone != 1) begin errors++; $display("FAIL odd_done got %0d want 1", ndone); end
   endtask

   task automatic test_reset_mid;
      int         nres, first_v, ndone, done_cyc, nrd, stall_bad;
      logic [7:0] expv [4] = '{8'd6, 8'd8, 8'd14, 8'd16};
      for (int k = 0; k < 16; k++) mem_a[k] = 8'(k + 1);
      a_ready = 1'b1;
      @(negedge clk);
      a_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      a_start = 1'b0;
      for (int cyc = 1; cyc < 8; cyc++) begin
         @(posedge clk);
         @(negedge clk);
      end
      // Cycle 8 lies inside the second window's reads
      checks++; if (a_rd_en !== 1'b1) begin errors++; $display("FAIL mid_in_read got %b want 1", a_rd_en); end
      rst = 1'b0;
      #1;
      checks++;
      if ({a_rd_en, a_rd_addr, a_d_out, a_ch, a_valid, a_busy, a_done} !== 19'd0) begin
         errors++; $display("FAIL mid_reset_outputs got %h want 0", {a_rd_en, a_rd_addr, a_d_out, a_ch, a_valid, a_busy, a_done});
      end
      @(posedge clk);
      @(negedge clk);
      checks++;
      if ({a_rd_en, a_valid, a_busy, a_done} !== 4'b0000) begin
         errors++; $display("FAIL mid_reset_held got %b want 0000", {a_rd_en, a_valid, a_busy, a_done});
      end
      rst = 1'b1;
      repeat (3) begin
         @(posedge clk);
         @(negedge clk);
      end
      checks++;
      if ({a_valid, a_busy} !== 2'b00) begin errors++; $display("FAIL post_reset_idle got %b want 00", {a_valid, a_busy}); end
      run_a(-1, 3, nres, first_v, ndone, done_cyc, nrd, stall_bad);
      checks++; if (nres != 4) begin errors++; $display("FAIL restart_count got %0d want 4", nres); end
      for (int k = 0; k < 4; k++) begin
         checks++;
         if (res_a[k] !== expv[k]) begin errors++; $display("FAIL restart_res%0d got %0d want %0d", k, res_a[k], expv[k]); end
         $display("restart result %0d: d_out=%0d", k, res_a[k]);
      end
      checks++; if (ndone != 1) begin errors++; $display("FAIL restart_done got %0d want 1", ndone); end
      checks++; if (done_cyc != 25) begin errors++; $display("FAIL restart_done_cycle got %0d want 25", done_cyc); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_relu();
      test_backpressure();
      test_channels();
      test_odd_size();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
